// File: rtl/rvc_asap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rvc_asap_pkg                                                   |
// | Brief   : CR_MEM register offsets, window size and load alignment helper |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rvc_asap_pkg;

    localparam int CR_WIN_BITS = 6;

    localparam logic [3:0] CR_SEG7_0 = 4'h0;
    localparam logic [3:0] CR_SEG7_1 = 4'h1;
    localparam logic [3:0] CR_SEG7_2 = 4'h2;
    localparam logic [3:0] CR_SEG7_3 = 4'h3;
    localparam logic [3:0] CR_SEG7_4 = 4'h4;
    localparam logic [3:0] CR_SEG7_5 = 4'h5;
    localparam logic [3:0] CR_LED    = 4'h6;
    localparam logic [3:0] CR_BTN0   = 4'h7;
    localparam logic [3:0] CR_BTN1   = 4'h8;
    localparam logic [3:0] CR_SWITCH = 4'h9;
    localparam logic [3:0] CR_EVENT  = 4'hA;

    typedef struct packed {
        logic [5:0][6:0] seg7;
        logic [9:0]      led;
        logic [1:0]      evt;
    } t_cr_regs;

    // Pick the lowest enabled lane and right-align it; unknown patterns pass the raw word.
    function automatic logic [31:0] cr_load_align(input logic [31:0] w,
                                                  input logic [3:0]  be,
                                                  input logic        sx);
        logic [31:0] r;
        r = w;
        case (be)
            4'b0001: r = {{24{sx & w[7]}},  w[7:0]};
            4'b0010: r = {{24{sx & w[15]}}, w[15:8]};
            4'b0100: r = {{24{sx & w[23]}}, w[23:16]};
            4'b1000: r = {{24{sx & w[31]}}, w[31:24]};
            4'b0011: r = {{16{sx & w[15]}}, w[15:0]};
            4'b1100: r = {{16{sx & w[31]}}, w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvc_asap_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rvc_asap_debounce                                              |
// | Brief   : 2-flop synchronizer, plus debouncer when RVC_CR_DEBOUNCE_EN    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rvc_asap_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic Clock,
    input  logic Rst,
    input  logic i_raw,
    output logic o_clean
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

`ifdef RVC_CR_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else if (r_sync == r_clean) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_clean <= r_sync;
            r_cnt   <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_clean = r_clean;
`else
    assign o_clean = r_sync;
`endif

endmodule
`default_nettype wire

// File: rtl/rvc_asap_5pl_cr_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rvc_asap_5pl_cr_resp                                           |
// | Brief   : CR_MEM responder (SEG7/LED/BTN/SWITCH/EVENT); RVC_CR_DEBOUNCE_EN|
// |           enables button debouncing                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rvc_asap_5pl_cr_resp
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] CR_BASE         = 32'h00FE_0000,
    parameter int          DEBOUNCE_CYCLES = 500_000
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] AluOut,
    input  logic [31:0] RegRdData2,
    input  logic [3:0]  CtrlDMemByteEn,
    input  logic        CtrlDMemWrEn,
    input  logic        SelDMemWb,
    input  logic        CtrlSignExt,
    output logic [31:0] CrRdDataQ104H,
    output logic        CrHitQ104H,
    input  logic        Button_0,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    output logic [6:0]  SEG7_0,
    output logic [6:0]  SEG7_1,
    output logic [6:0]  SEG7_2,
    output logic [6:0]  SEG7_3,
    output logic [6:0]  SEG7_4,
    output logic [6:0]  SEG7_5,
    output logic [9:0]  LED
);
    t_cr_regs    r_regs;
    logic [9:0]  r_sw_meta;
    logic [9:0]  r_sw_sync;
    logic [1:0]  r_btn_prev;
    logic [31:0] r_rd_data;
    logic        r_hit;

    logic        w_btn0;
    logic        w_btn1;
    logic        w_hit;
    logic [3:0]  w_off;
    logic [31:0] w_rd_word;
    logic [1:0]  w_evt_set;
    logic [1:0]  w_evt_clr;
    logic        w_wr;

    assign w_hit = (AluOut[31:CR_WIN_BITS] == CR_BASE[31:CR_WIN_BITS]);
    assign w_off = AluOut[CR_WIN_BITS-1:2];
    assign w_wr  = w_hit & CtrlDMemWrEn;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, AluOut[1:0], RegRdData2[31:16], CR_BASE[CR_WIN_BITS-1:0]};

    rvc_asap_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
        .Clock   (Clock),
        .Rst     (Rst),
        .i_raw   (Button_0),
        .o_clean (w_btn0)
    );

    rvc_asap_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
        .Clock   (Clock),
        .Rst     (Rst),
        .i_raw   (Button_1),
        .o_clean (w_btn1)
    );

    assign w_evt_set = {w_btn1, w_btn0} & ~r_btn_prev;
    assign w_evt_clr = (w_wr && w_off == CR_EVENT && CtrlDMemByteEn[0]) ? RegRdData2[1:0] : 2'b00;

    always_comb begin
        w_rd_word = 32'h0;
        for (int i = 0; i < 6; i++) begin
            if (w_off == 4'(i)) w_rd_word = {25'h0, r_regs.seg7[i]};
        end
        case (w_off)
            CR_LED:    w_rd_word = {22'h0, r_regs.led};
            CR_BTN0:   w_rd_word = {31'h0, w_btn0};
            CR_BTN1:   w_rd_word = {31'h0, w_btn1};
            CR_SWITCH: w_rd_word = {22'h0, r_sw_sync};
            CR_EVENT:  w_rd_word = {30'h0, r_regs.evt};
            default:   ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_regs.seg7 <= {6{7'h7F}};
            r_regs.led  <= 10'h0;
            r_regs.evt  <= 2'b00;
            r_sw_meta   <= 10'h0;
            r_sw_sync   <= 10'h0;
            r_btn_prev  <= 2'b00;
            r_rd_data   <= 32'h0;
            r_hit       <= 1'b0;
        end else begin
            r_sw_meta  <= Switch;
            r_sw_sync  <= r_sw_meta;
            r_btn_prev <= {w_btn1, w_btn0};
            // Set is OR'ed after the clear so a simultaneous press is never lost.
            r_regs.evt <= (r_regs.evt & ~w_evt_clr) | w_evt_set;

            if (w_wr) begin
                for (int i = 0; i < 6; i++) begin
                    if (w_off == 4'(i) && CtrlDMemByteEn[0]) r_regs.seg7[i] <= RegRdData2[6:0];
                end
                if (w_off == CR_LED) begin
                    if (CtrlDMemByteEn[0]) r_regs.led[7:0] <= RegRdData2[7:0];
                    if (CtrlDMemByteEn[1]) r_regs.led[9:8] <= RegRdData2[9:8];
                end
            end

            if (w_hit && SelDMemWb) begin
                r_hit     <= 1'b1;
                r_rd_data <= cr_load_align(w_rd_word, CtrlDMemByteEn, CtrlSignExt);
            end else begin
                r_hit     <= 1'b0;
                r_rd_data <= 32'h0;
            end
        end
    end

    assign CrRdDataQ104H = r_rd_data;
    assign CrHitQ104H    = r_hit;
    assign SEG7_0        = r_regs.seg7[0];
    assign SEG7_1        = r_regs.seg7[1];
    assign SEG7_2        = r_regs.seg7[2];
    assign SEG7_3        = r_regs.seg7[3];
    assign SEG7_4        = r_regs.seg7[4];
    assign SEG7_5        = r_regs.seg7[5];
    assign LED           = r_regs.led;

endmodule
`default_nettype wire

// File: tb/tb_rvc_asap_5pl_cr_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rvc_asap_5pl_cr_resp                                        |
// | Brief   : Scoreboard bench for the CR_MEM responder                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rvc_asap_5pl_cr_resp;

    localparam int DC = 8;
`ifdef RVC_CR_DEBOUNCE_EN
    localparam int LAT = 3 + DC;
`else
    localparam int LAT = 3;
`endif

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] AluOut = 32'h0;
    logic [31:0] RegRdData2 = 32'h0;
    logic [3:0]  CtrlDMemByteEn = 4'h0;
    logic        CtrlDMemWrEn = 1'b0;
    logic        SelDMemWb = 1'b0;
    logic        CtrlSignExt = 1'b0;
    logic [31:0] CrRdDataQ104H;
    logic        CrHitQ104H;
    logic        Button_0 = 1'b0;
    logic        Button_1 = 1'b0;
    logic [9:0]  Switch = 10'h0;
    logic [6:0]  SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
    logic [9:0]  LED;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    logic        pend = 1'b0;

    always #5 Clock = ~Clock;

    rvc_asap_5pl_cr_resp #(.CR_BASE(32'h00FE_0000), .DEBOUNCE_CYCLES(DC)) dut (
        .Clock          (Clock),
        .Rst            (Rst),
        .AluOut         (AluOut),
        .RegRdData2     (RegRdData2),
        .CtrlDMemByteEn (CtrlDMemByteEn),
        .CtrlDMemWrEn   (CtrlDMemWrEn),
        .SelDMemWb      (SelDMemWb),
        .CtrlSignExt    (CtrlSignExt),
        .CrRdDataQ104H  (CrRdDataQ104H),
        .CrHitQ104H     (CrHitQ104H),
        .Button_0       (Button_0),
        .Button_1       (Button_1),
        .Switch         (Switch),
        .SEG7_0         (SEG7_0),
        .SEG7_1         (SEG7_1),
        .SEG7_2         (SEG7_2),
        .SEG7_3         (SEG7_3),
        .SEG7_4         (SEG7_4),
        .SEG7_5         (SEG7_5),
        .LED            (LED)
    );

    // A load sampled at one edge is checked on the following negedge.
    always @(posedge Clock) pend <= SelDMemWb & ~Rst;

    always @(negedge Clock) begin
        logic [32:0] e;
        if (pend) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL load_resp: response with empty scoreboard, hit=%0b data=%h", CrHitQ104H, CrRdDataQ104H);
            end else begin
                e = exp_q.pop_front();
                if ({CrHitQ104H, CrRdDataQ104H} !== e) begin
                    fails++;
                    $display("FAIL load_resp: got hit=%0b data=%h, expected hit=%0b data=%h",
                             CrHitQ104H, CrRdDataQ104H, e[32], e[31:0]);
                end
            end
        end else if (!Rst && CrHitQ104H !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL spurious_hit: got hit=%0b data=%h, expected hit=0", CrHitQ104H, CrRdDataQ104H);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge Clock);
        #1;
        CtrlDMemWrEn = 1'b0;
        SelDMemWb    = 1'b0;
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic we, input logic ld, input logic sx,
                       input logic eh, input logic [31:0] ed);
        @(posedge Clock);
        #1;
        AluOut         = a;
        RegRdData2     = d;
        CtrlDMemByteEn = be;
        CtrlDMemWrEn   = we;
        SelDMemWb      = ld;
        CtrlSignExt    = sx;
        if (ld) exp_q.push_back({eh, ed});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        Rst = 1'b0;
        chk("reset_led", {22'h0, LED}, 32'h0);
        chk("reset_seg7_0", {25'h0, SEG7_0}, 32'h7F);
        chk("reset_seg7_5", {25'h0, SEG7_5}, 32'h7F);

        cyc(32'h00FE_0000, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h7F);
        cyc(32'h00FE_0028, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h0);

        cyc(32'h00FE_0018, 32'h2AA, 4'b1111, 1, 0, 0, 0, 0);
        idle();
        chk("led_sw", {22'h0, LED}, 32'h2AA);
        cyc(32'h00FE_0018, 32'h55, 4'b0001, 1, 0, 0, 0, 0);
        idle();
        chk("led_sb", {22'h0, LED}, 32'h255);
        cyc(32'h00FE_0018, 32'h0, 4'b0011, 0, 1, 0, 1, 32'h255);
        cyc(32'h00FE_0019, 32'h0, 4'b0010, 0, 1, 0, 1, 32'h02);

        Switch = 10'h3F0;
        repeat (3) idle();
        cyc(32'h00FE_0024, 32'h0, 4'b0001, 0, 1, 1, 1, 32'hFFFF_FFF0);
        cyc(32'h00FE_0024, 32'h0, 4'b0001, 0, 1, 0, 1, 32'h0000_00F0);
        cyc(32'h00FE_0024, 32'h0, 4'b0011, 0, 1, 1, 1, 32'h0000_03F0);
        cyc(32'h00FE_0026, 32'h0, 4'b1100, 0, 1, 1, 1, 32'h0);

        cyc(32'h00FE_000C, 32'h1234_5640, 4'b0001, 1, 0, 0, 0, 0);
        cyc(32'h00FE_000C, 32'h0000_FFFF, 4'b0010, 1, 0, 0, 0, 0);
        idle();
        chk("seg7_3_lane0_only", {25'h0, SEG7_3}, 32'h40);
        chk("seg7_2_untouched", {25'h0, SEG7_2}, 32'h7F);
        cyc(32'h00FE_000C, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h40);

        cyc(32'h00FE_0018, 32'h3FF, 4'b1111, 1, 1, 0, 1, 32'h255);
        idle();
        chk("led_after_ld_wr", {22'h0, LED}, 32'h3FF);

`ifdef RVC_CR_DEBOUNCE_EN
        Button_0 = 1'b1;
        repeat (DC / 2) idle();
        Button_0 = 1'b0;
        repeat (DC + 5) idle();
        cyc(32'h00FE_0028, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h0);
        Button_0 = 1'b1;
        repeat (DC + 5) idle();
`else
        Button_0 = 1'b1;
        repeat (3) idle();
`endif
        cyc(32'h00FE_0028, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h1);

        Button_1 = 1'b1;
        repeat (LAT + 2) idle();
        cyc(32'h00FE_0028, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h3);
        Button_0 = 1'b0;
        repeat (LAT + 2) idle();
        cyc(32'h00FE_001C, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h0);

        // New Button_0 edge lands on the same edge as a W1C of bit 0.
        Button_0 = 1'b1;
        repeat (LAT - 2) idle();
        cyc(32'h00FE_0028, 32'h1, 4'b0001, 1, 0, 0, 0, 0);
        cyc(32'h00FE_0028, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h3);
        cyc(32'h00FE_0028, 32'h3, 4'b0001, 1, 0, 0, 0, 0);
        cyc(32'h00FE_0028, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h0);

        cyc(32'h00FE_001C, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h1);
        cyc(32'h00FE_0020, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h1);
        cyc(32'h00FF_0000, 32'h0, 4'b1111, 0, 1, 0, 0, 32'h0);
        cyc(32'h00FE_0030, 32'hFFFF_FFFF, 4'b1111, 1, 0, 0, 0, 0);
        cyc(32'h00FE_0030, 32'h0, 4'b1111, 0, 1, 0, 1, 32'h0);
        idle();
        chk("reserved_led", {22'h0, LED}, 32'h3FF);
        chk("reserved_seg7_0", {25'h0, SEG7_0}, 32'h7F);
        chk("reserved_seg7_3", {25'h0, SEG7_3}, 32'h40);
        repeat (3) idle();
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvc_asap_5pl_cr_resp.md
# rvc_asap_5pl_cr_resp

Control-register (CR_MEM) responder for the 5-stage core's data-memory interface. Decodes the Q103H D_MEM request driven by the core (AluOut, RegRdData2, CtrlDMemByteEn, CtrlDMemWrEn, SelDMemWb, CtrlSignExt), performs byte-enabled writes to FPGA output registers and returns read data at Q104H. Synchronizes, and optionally debounces, buttons and switches, and latches button press events. Sits inside the memory wrapper beside D_MEM; the wrapper muxes `CrRdDataQ104H` into `DMemRdDataQ104H` when `CrHitQ104H` is set.

## Interface
Parameters:
- `CR_BASE`, default `32'h00FE_0000`: 64-byte-aligned base address of the window.
- `DEBOUNCE_CYCLES`, default `500_000`: number of stable cycles required to accept a button change.

Ports:
- `Clock` in 1: single clock.
- `Rst` in 1: synchronous, active-high reset.
- `AluOut` in 32: Q103H address.
- `RegRdData2` in 32: Q103H write data.
- `CtrlDMemByteEn` in 4: Q103H byte enables.
- `CtrlDMemWrEn` in 1: Q103H write strobe.
- `SelDMemWb` in 1: Q103H load request.
- `CtrlSignExt` in 1: Q103H sign-extend load.
- `CrRdDataQ104H` out 32: load data.
- `CrHitQ104H` out 1: the Q104H load targeted the window.
- `Button_0`, `Button_1` in 1: asynchronous, active-high.
- `Switch` in 10: asynchronous.
- `SEG7_0`..`SEG7_5` out 7: active-low segments.
- `LED` out 10: LEDs.

## Operation
- Hit: `AluOut[31:6] == CR_BASE[31:6]`. Offset is `AluOut[5:2]`; `AluOut[1:0]` is ignored.
- Register map:
  - Offsets 0x00–0x14: SEG7_0..5, RW, bits [6:0].
  - 0x18: LED, RW, bits [9:0].
  - 0x1C: BTN0, RO.
  - 0x20: BTN1, RO.
  - 0x24: SWITCH, RO, bits [9:0].
  - 0x28: EVENT, RW1C; bit0 = BTN0 press, bit1 = BTN1 press.
  - 0x2C–0x3C: reserved; read 0, writes ignored.
- Write: on a hit with `CtrlDMemWrEn`, the write is applied per byte lane. SEG7 uses lane 0 only. LED uses lanes 0–1. EVENT clears bits where lane 0 is enabled and the data bit is 1. Writes to RO registers are dropped.
- Load: on a hit with `SelDMemWb`, the addressed word is taken from the lowest enabled lane and right-aligned.
  - Byte enable 0001/0010/0100/1000 selects a byte; 0011/1100 selects a halfword; 1111 selects the word.
  - Sign-extended if `CtrlSignExt`, else zero-extended.
  - Unlisted enable patterns return the raw word.
- Inputs: Switch and both buttons pass through a 2-flop synchronizer. Buttons optionally pass through a debouncer (see Configuration).
- Events: a 0→1 edge of a conditioned button sets its EVENT bit. If a set and a W1C clear hit the same cycle, set wins.
- Reset values:
  - SEG7_0..5 = 7'h7F (all segments off).
  - LED = 0.
  - EVENT = 0.
  - Synchronizers and debouncers = 0.
  - `CrRdDataQ104H` = 0, `CrHitQ104H` = 0.

## Timing
- Write at Q103H edge N is visible on SEG7/LED outputs after edge N (registered outputs).
- Load at Q103H: `CrRdDataQ104H` and `CrHitQ104H` are registered, valid in the following cycle (Q104H).
- `CrHitQ104H` = 0 when there is no load or no hit; in that case `CrRdDataQ104H` is held at 0.
- A load and a write in the same cycle to the same register: the load returns the old value.
- Switch and button synchronizer latency: 2 cycles.
- Debounce counter:
  - Resets whenever the raw synchronized value equals the debounced value.
  - Otherwise it increments.
  - At `DEBOUNCE_CYCLES-1` the debounced value takes the raw value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`; it saturates and never wraps.
- `Rst` asserted mid-debounce clears counters and debounced state on the next edge.

## Configuration
- `RVC_CR_DEBOUNCE_EN` defined: buttons are debounced per Timing, so a press reaches BTN/EVENT after 2 + `DEBOUNCE_CYCLES` cycles.
- Not defined: buttons use the 2-flop synchronizer only (2-cycle latency), and no counters are instantiated.

## Structure
- `rvc_asap_pkg` holds:
  - offset constants `CR_SEG7_0` .. `CR_EVENT` (word offsets 0x0–0xA);
  - `CR_WIN_BITS = 6`;
  - typedef `t_cr_regs` (SEG7 array, LED, EVENT).
- One sub-module `rvc_asap_debounce` (sync + optional debounce, one instance per button), parameterized by `DEBOUNCE_CYCLES`.

## Test plan
- Reset, then load word at 0x00FE0000: `CrHitQ104H` = 1 and `CrRdDataQ104H` = 32'h7F one cycle later. `LED` = 0.
- `sw` 32'h0000_02AA at 0x00FE0018, enable 1111: `LED` = 10'h2AA after the edge. Then enable 0001 with data 32'h55: `LED` = 10'h255.
- `Switch` = 10'h3F0, then `lb` at 0x00FE0024, enable 0001, `CtrlSignExt` = 1: returns 32'hFFFF_FFF0. With `lbu`: returns 32'h0000_00F0.
- Button_0 pulse held for `DEBOUNCE_CYCLES`+5 with the macro defined: EVENT = 1. A pulse of `DEBOUNCE_CYCLES`/2 leaves EVENT = 0. Without the macro, EVENT = 1 after 3 cycles.
- EVENT = 3, write 32'h1 to 0x00FE0028 in the same cycle as a new Button_0 edge: EVENT = 3 (set wins). The next W1C of 32'h3 gives EVENT = 0.
- Load at 0x00FF0000 (miss): `CrHitQ104H` = 0, data = 0. Write to 0x00FE0030 (reserved): no output changes.
